// File: rtl/acs_metric_update.sv
// acs_metric_update: add-compare-select engine of the K=9, rate-1/2 Viterbi decoder.
// Each accepted symbol runs one 256-state trellis step as 64 write cycles of 4 metrics,
// reading old metrics from and writing new metrics to the ping-pong metric memory.
// Optional build macro ACS_NORM_EN: when every metric written in a step has its MSB set,
// the next step subtracts 2^(WD_METR-1) from each read metric before the add.
module acs_metric_update #(
  parameter int unsigned WD_METR = 8,
  parameter int unsigned N_ACS   = 4,
  parameter int unsigned WD_BM   = 4,
  parameter logic [8:0]  G0      = 9'o561,
  parameter logic [8:0]  G1      = 9'o753
) (
  input  logic                           Clock1,
  input  logic                           Reset,
  input  logic                           Active,
  input  logic                           SymValid,
  input  logic [4*WD_BM-1:0]             SymBM,
  output logic                           SymReady,
  output logic [4:0]                     MMReadAddress,
  input  logic [2*N_ACS*WD_METR-1:0]     MMPathMetric,
  output logic [5:0]                     MMWriteAddress,
  output logic [N_ACS*WD_METR-1:0]       MMMetric,
  output logic                           MMWriteEnable,
  output logic                           MMBlockSelect,
  output logic [N_ACS-1:0]               SurvBits,
  output logic                           SurvValid,
  output logic                           StepDone
);

  localparam int unsigned N_RD   = 2 * N_ACS;
  localparam int unsigned WD_SUM = WD_METR + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [5:0] CNT_LAST = 6'd63;

  logic [1:0]                 r_state, w_state_nxt;
  logic [5:0]                 r_cnt, w_cnt_nxt;
  logic [4*WD_BM-1:0]         r_bm, w_bm_nxt;
  logic [5:0]                 r_waddr, w_waddr_nxt;
  logic [N_ACS*WD_METR-1:0]   r_metric, w_metric_nxt;
  logic [N_ACS-1:0]           r_surv, w_surv_nxt;
  logic                       r_we, w_we_nxt;
  logic                       r_done, w_done_nxt;
  logic                       r_bsel, w_bsel_nxt;
  logic                       r_ready, w_ready_nxt;

  logic [N_RD*WD_METR-1:0]    w_pm;
  logic [N_ACS*WD_METR-1:0]   w_m0, w_m1, w_acs_metric;
  logic [2*N_ACS-1:0]         w_l0, w_l1;
  logic [N_ACS-1:0]           w_acs_surv;
  logic [4:0]                 w_r;
  logic                       w_phase;

`ifdef ACS_NORM_EN
  logic                       r_norm, w_norm_nxt;
  logic                       r_all_msb, w_all_msb_nxt;
  logic [N_ACS-1:0]           w_acs_msb;
`endif

  // Encoder output pair {c0,c1} for the transition from predecessor p with input bit u.
  function automatic logic [1:0] branch_label(input logic u, input logic [7:0] p);
    logic [8:0] v;
    v = {u, p};
    return {^(v & G0), ^(v & G1)};
  endfunction

  // Path metric plus branch metric, clamped at the all-ones metric value.
  function automatic logic [WD_METR-1:0] sat_add(input logic [WD_METR-1:0] pm,
                                                 input logic [WD_BM-1:0]   bm);
    logic [WD_SUM-1:0] s;
    s = WD_SUM'(pm) + WD_SUM'(bm);
    return s[WD_METR] ? {WD_METR{1'b1}} : s[WD_METR-1:0];
  endfunction

  assign w_r     = r_cnt[5:1];
  assign w_phase = r_cnt[0];

  // Unpack the read word, optionally rebasing every metric down by half range.
  always_comb begin
    w_pm = MMPathMetric;
`ifdef ACS_NORM_EN
    if (r_norm) begin
      for (int unsigned k = 0; k < N_RD; k++) begin
        if (w_pm[k*WD_METR + WD_METR - 1])
          w_pm[k*WD_METR + WD_METR - 1 +: 1] = 1'b0;
        else
          w_pm[k*WD_METR +: WD_METR] = '0;
      end
    end
`endif
  end

  // Four butterflies-worth of add-compare-select; successor 4r+i (+128 in phase 1).
  always_comb begin
    w_l0         = '0;
    w_l1         = '0;
    w_m0         = '0;
    w_m1         = '0;
    w_acs_metric = '0;
    w_acs_surv   = '0;
    for (int unsigned i = 0; i < N_ACS; i++) begin
      w_l0[2*i +: 2] = branch_label(w_phase, {w_r, 2'(i), 1'b0});
      w_l1[2*i +: 2] = branch_label(w_phase, {w_r, 2'(i), 1'b1});
      w_m0[i*WD_METR +: WD_METR] =
        sat_add(w_pm[(2*i)*WD_METR +: WD_METR], r_bm[32'(w_l0[2*i +: 2]) * WD_BM +: WD_BM]);
      w_m1[i*WD_METR +: WD_METR] =
        sat_add(w_pm[(2*i+1)*WD_METR +: WD_METR], r_bm[32'(w_l1[2*i +: 2]) * WD_BM +: WD_BM]);
      // Ties keep the even predecessor.
      w_acs_surv[i +: 1] = (w_m1[i*WD_METR +: WD_METR] < w_m0[i*WD_METR +: WD_METR]);
      w_acs_metric[i*WD_METR +: WD_METR] = w_acs_surv[i +: 1] ? w_m1[i*WD_METR +: WD_METR]
                                                              : w_m0[i*WD_METR +: WD_METR];
    end
  end

`ifdef ACS_NORM_EN
  // MSB of each metric produced this cycle, for the all-high tracking flag.
  always_comb begin
    w_acs_msb = '0;
    for (int unsigned i = 0; i < N_ACS; i++)
      w_acs_msb[i +: 1] = w_acs_metric[i*WD_METR + WD_METR - 1 +: 1];
  end
`endif

  // Next-state and next-output decode for the IDLE/RUN/FLUSH sequencer.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bm_nxt     = r_bm;
    w_waddr_nxt  = r_waddr;
    w_metric_nxt = r_metric;
    w_surv_nxt   = r_surv;
    w_we_nxt     = 1'b0;
    w_done_nxt   = 1'b0;
    w_bsel_nxt   = r_bsel;
    w_ready_nxt  = r_ready;
`ifdef ACS_NORM_EN
    w_norm_nxt    = r_norm;
    w_all_msb_nxt = r_all_msb;
`endif
    case (r_state)
      IDLE: begin
        if (SymValid) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
          w_bm_nxt    = SymBM;
          w_ready_nxt = 1'b0;
`ifdef ACS_NORM_EN
          w_all_msb_nxt = 1'b1;
`endif
        end
      end
      RUN: begin
        w_cnt_nxt    = r_cnt + 6'd1;
        w_we_nxt     = 1'b1;
        w_waddr_nxt  = {w_phase, w_r};
        w_metric_nxt = w_acs_metric;
        w_surv_nxt   = w_acs_surv;
`ifdef ACS_NORM_EN
        w_all_msb_nxt = r_all_msb & (&w_acs_msb);
`endif
        if (r_cnt == CNT_LAST)
          w_state_nxt = FLUSH;
      end
      FLUSH: begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
        w_bsel_nxt  = ~r_bsel;
        w_ready_nxt = 1'b1;
`ifdef ACS_NORM_EN
        w_norm_nxt  = r_all_msb;
`endif
      end
      default: begin
        w_state_nxt = IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  // State register; Active=0 freezes the sequencer.
  always_ff @(posedge Clock1) begin
    if (Reset)
      r_state <= IDLE;
    else if (Active)
      r_state <= w_state_nxt;
  end

  // Counter, latched branch metrics and registered memory/decision outputs.
  always_ff @(posedge Clock1) begin
    if (Reset) begin
      r_cnt    <= '0;
      r_bm     <= '0;
      r_waddr  <= '0;
      r_metric <= '0;
      r_surv   <= '0;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
      r_bsel   <= 1'b0;
      r_ready  <= 1'b1;
`ifdef ACS_NORM_EN
      r_norm    <= 1'b0;
      r_all_msb <= 1'b0;
`endif
    end else if (Active) begin
      r_cnt    <= w_cnt_nxt;
      r_bm     <= w_bm_nxt;
      r_waddr  <= w_waddr_nxt;
      r_metric <= w_metric_nxt;
      r_surv   <= w_surv_nxt;
      r_we     <= w_we_nxt;
      r_done   <= w_done_nxt;
      r_bsel   <= w_bsel_nxt;
      r_ready  <= w_ready_nxt;
`ifdef ACS_NORM_EN
      r_norm    <= w_norm_nxt;
      r_all_msb <= w_all_msb_nxt;
`endif
    end
  end

  assign SymReady       = r_ready;
  assign MMReadAddress  = r_cnt[5:1];
  assign MMWriteAddress = r_waddr;
  assign MMMetric       = r_metric;
  assign MMWriteEnable  = r_we;
  assign SurvValid      = r_we;
  assign SurvBits       = r_surv;
  assign MMBlockSelect  = r_bsel;
  assign StepDone       = r_done;

endmodule

// File: tb/tb_acs_metric_update.sv
// tb_acs_metric_update: directed bench for the Viterbi ACS metric-update engine.
module tb_acs_metric_update;

  localparam logic [8:0] G0 = 9'o561;
  localparam logic [8:0] G1 = 9'o753;
`ifdef ACS_NORM_EN
  localparam bit NORM_BUILD = 1'b1;
`else
  localparam bit NORM_BUILD = 1'b0;
`endif

  logic        Clock1 = 1'b0;
  logic        Reset, Active, SymValid;
  logic [15:0] SymBM;
  logic        SymReady;
  logic [4:0]  MMReadAddress;
  logic [63:0] MMPathMetric;
  logic [5:0]  MMWriteAddress;
  logic [31:0] MMMetric;
  logic        MMWriteEnable, MMBlockSelect;
  logic [3:0]  SurvBits;
  logic        SurvValid, StepDone;

  acs_metric_update dut (
    .Clock1(Clock1), .Reset(Reset), .Active(Active), .SymValid(SymValid), .SymBM(SymBM),
    .SymReady(SymReady), .MMReadAddress(MMReadAddress), .MMPathMetric(MMPathMetric),
    .MMWriteAddress(MMWriteAddress), .MMMetric(MMMetric), .MMWriteEnable(MMWriteEnable),
    .MMBlockSelect(MMBlockSelect), .SurvBits(SurvBits), .SurvValid(SurvValid),
    .StepDone(StepDone)
  );

  always #5 Clock1 = ~Clock1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_sv    = 0;
  int wr_n    = 0;
  int done_cnt = 0;
  int sv_err  = 0;

  logic [7:0]  rd_pm      [256];
  logic [5:0]  log_addr   [2048];
  logic [31:0] mem_metric [64];
  logic [3:0]  mem_surv   [64];

  always @(posedge Clock1) cyc <= cyc + 1;

  // Old-metric memory stub: combinational read of states 8r..8r+7.
  always_comb begin
    MMPathMetric = '0;
    for (int j = 0; j < 8; j++)
      MMPathMetric[j*8 +: 8] = rd_pm[{MMReadAddress, 3'(j)}];
  end

  // Write/done monitor, sampled shortly before the edge that commits them.
  always @(negedge Clock1) begin
    #3;
    if (Active && (MMWriteEnable !== SurvValid)) sv_err++;
    if (Active && MMWriteEnable) begin
      if (wr_n < 2048) log_addr[11'(wr_n)] = MMWriteAddress;
      mem_metric[MMWriteAddress] = MMMetric;
      mem_surv[MMWriteAddress]   = SurvBits;
      wr_n++;
    end
    if (Active && StepDone) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] lbl(input bit u, input logic [7:0] p);
    logic [8:0] v;
    v = {u, p};
    return {^(v & G0), ^(v & G1)};
  endfunction

  // Reference for successor state s: {decision, new metric}.
  function automatic logic [8:0] ref_state(input int s, input logic [15:0] bm, input bit norm);
    int p0, p1, pm0, pm1, m0, m1;
    bit u, dec;
    logic [1:0] l0, l1;
    u   = (s >= 128);
    p0  = (2 * s) % 256;
    p1  = p0 + 1;
    l0  = lbl(u, 8'(p0));
    l1  = lbl(u, 8'(p1));
    pm0 = int'(rd_pm[8'(p0)]);
    pm1 = int'(rd_pm[8'(p1)]);
    if (norm) begin
      pm0 = (pm0 >= 128) ? pm0 - 128 : 0;
      pm1 = (pm1 >= 128) ? pm1 - 128 : 0;
    end
    m0 = pm0 + int'(bm[l0*4 +: 4]);
    m1 = pm1 + int'(bm[l1*4 +: 4]);
    if (m0 > 255) m0 = 255;
    if (m1 > 255) m1 = 255;
    dec = (m1 < m0);
    return {dec, 8'(dec ? m1 : m0)};
  endfunction

  task automatic send_sym(input logic [15:0] bm);
    @(negedge Clock1);
    SymValid = 1'b1;
    SymBM    = bm;
    t_sv     = cyc;
    @(negedge Clock1);
    SymValid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int n;
    n   = 0;
    lat = -1;
    while (StepDone !== 1'b1 && n < 300) begin
      @(negedge Clock1);
      n++;
    end
    if (StepDone === 1'b1) lat = cyc - t_sv;
    @(negedge Clock1);
  endtask

  task automatic check_step(input string tag, input int base, input logic [15:0] bm, input bit norm);
    int order_err, data_err, s;
    logic [5:0] ea;
    logic [8:0] e;
    order_err = 0;
    data_err  = 0;
    chk({tag, " wr_count"}, 32'(wr_n - base), 32'd64);
    for (int k = 0; k < 64; k++) begin
      ea = 6'((k % 2) * 32 + k / 2);
      if (base + k >= 2048 || log_addr[11'(base + k)] !== ea) order_err++;
    end
    for (int a = 0; a < 64; a++) begin
      for (int i = 0; i < 4; i++) begin
        s = (a / 32) * 128 + (a % 32) * 4 + i;
        e = ref_state(s, bm, norm);
        if (mem_metric[6'(a)][i*8 +: 8] !== e[7:0]) data_err++;
        if (mem_surv[6'(a)][i +: 1] !== e[8]) data_err++;
      end
    end
    chk({tag, " addr_order_errs"}, 32'(order_err), 32'd0);
    chk({tag, " data_errs"}, 32'(data_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base, exp_done;
    logic exp_bsel;
    logic [8:0]  e;
    logic [31:0] ew;
    localparam logic [15:0] BM1 = 16'h4321;
    localparam logic [15:0] BM2 = 16'h7A05;
    localparam logic [15:0] BM3 = 16'h28C6;

    Reset = 1'b1; Active = 1'b1; SymValid = 1'b0; SymBM = '0;
    exp_done = 0; exp_bsel = 1'b0;
    for (int k = 0; k < 256; k++) rd_pm[k] = 8'd0;
    repeat (3) @(negedge Clock1);

    // Reset state
    chk("rst SymReady", 32'(SymReady), 32'd1);
    chk("rst MMWriteEnable", 32'(MMWriteEnable), 32'd0);
    chk("rst SurvValid", 32'(SurvValid), 32'd0);
    chk("rst StepDone", 32'(StepDone), 32'd0);
    chk("rst MMBlockSelect", 32'(MMBlockSelect), 32'd0);
    chk("rst MMReadAddress", 32'(MMReadAddress), 32'd0);
    chk("rst MMWriteAddress", 32'(MMWriteAddress), 32'd0);
    chk("rst MMMetric", MMMetric, 32'd0);
    chk("rst SurvBits", 32'(SurvBits), 32'd0);
    Reset = 1'b0;

    // Step 1: zero metrics, BM00=1 BM01=2 BM10=3 BM11=4
    base = wr_n;
    send_sym(BM1);
    wait_done(lat);
    exp_done++; exp_bsel = ~exp_bsel;
    chk("s1 latency", 32'(lat), 32'd66);
    check_step("s1", base, BM1, 1'b0);
    chk("s1 addr0 slot0 metric", 32'(mem_metric[0][7:0]), 32'd1);
    chk("s1 addr0 slot0 surv", 32'(mem_surv[0][0]), 32'd0);
    chk("s1 addr0 slot1 metric", 32'(mem_metric[0][15:8]), 32'd2);
    chk("s1 addr32 slot0 metric", 32'(mem_metric[32][7:0]), 32'd1);
    chk("s1 addr32 slot0 surv", 32'(mem_surv[32][0]), 32'd1);
    chk("s1 done count", 32'(done_cnt), 32'(exp_done));
    chk("s1 StepDone one cycle", 32'(StepDone), 32'd0);
    chk("s1 MMBlockSelect", 32'(MMBlockSelect), 32'(exp_bsel));
    chk("s1 SymReady", 32'(SymReady), 32'd1);

    // Step 2: odd predecessor wins, tie keeps even predecessor
    rd_pm[0] = 8'd5; rd_pm[1] = 8'd2; rd_pm[2] = 8'd7; rd_pm[3] = 8'd7;
    base = wr_n;
    send_sym(16'h0000);
    wait_done(lat);
    exp_done++; exp_bsel = ~exp_bsel;
    check_step("s2", base, 16'h0000, 1'b0);
    chk("s2 addr0 slot0 metric", 32'(mem_metric[0][7:0]), 32'd2);
    chk("s2 addr0 slot0 surv", 32'(mem_surv[0][0]), 32'd1);
    chk("s2 addr32 slot0 metric", 32'(mem_metric[32][7:0]), 32'd2);
    chk("s2 addr32 slot0 surv", 32'(mem_surv[32][0]), 32'd1);
    chk("s2 addr0 slot1 metric", 32'(mem_metric[0][15:8]), 32'd7);
    chk("s2 addr0 slot1 surv", 32'(mem_surv[0][1]), 32'd0);
    chk("s2 MMBlockSelect", 32'(MMBlockSelect), 32'(exp_bsel));

    // Step 3: saturation at 8'hFF
    for (int k = 0; k < 256; k++) rd_pm[k] = 8'hFE;
    base = wr_n;
    send_sym(16'hFFFF);
    wait_done(lat);
    exp_done++; exp_bsel = ~exp_bsel;
    check_step("s3 sat", base, 16'hFFFF, 1'b0);
    chk("s3 addr0 metric", mem_metric[0], 32'hFFFF_FFFF);
    chk("s3 addr63 metric", mem_metric[63], 32'hFFFF_FFFF);

    // Step 4: reads rebased by 128 only when normalization is built in
    base = wr_n;
    send_sym(16'h0000);
    wait_done(lat);
    exp_done++; exp_bsel = ~exp_bsel;
    check_step("s4 norm", base, 16'h0000, NORM_BUILD);
    chk("s4 addr5 metric", mem_metric[5], NORM_BUILD ? 32'h7E7E_7E7E : 32'hFEFE_FEFE);

    // Step 5: SymValid during RUN is ignored
    for (int k = 0; k < 256; k++) rd_pm[k] = 8'd0;
    base = wr_n;
    send_sym(BM1);
    repeat (10) @(negedge Clock1);
    chk("s5 cnt10 MMReadAddress", 32'(MMReadAddress), 32'd5);
    chk("s5 cnt10 SymReady", 32'(SymReady), 32'd0);
    SymValid = 1'b1; SymBM = 16'h0000;
    @(negedge Clock1);
    SymValid = 1'b0;
    wait_done(lat);
    exp_done++; exp_bsel = ~exp_bsel;
    chk("s5 latency", 32'(lat), 32'd66);
    check_step("s5", base, BM1, 1'b0);
    repeat (80) @(negedge Clock1);
    chk("s5 single StepDone", 32'(done_cnt), 32'(exp_done));
    chk("s5 no extra writes", 32'(wr_n - base), 32'd64);
    chk("s5 MMBlockSelect", 32'(MMBlockSelect), 32'(exp_bsel));

    // Step 6: reset mid-step abandons it
    for (int k = 0; k < 256; k++) rd_pm[k] = 8'((k * 7) % 200);
    send_sym(BM2);
    repeat (30) @(negedge Clock1);
    chk("s6 cnt30 MMReadAddress", 32'(MMReadAddress), 32'd15);
    Reset = 1'b1;
    @(negedge Clock1);
    Reset = 1'b0;
    exp_bsel = 1'b0;
    chk("s6 rst SymReady", 32'(SymReady), 32'd1);
    chk("s6 rst MMWriteEnable", 32'(MMWriteEnable), 32'd0);
    chk("s6 rst SurvValid", 32'(SurvValid), 32'd0);
    chk("s6 rst MMBlockSelect", 32'(MMBlockSelect), 32'd0);
    chk("s6 rst MMWriteAddress", 32'(MMWriteAddress), 32'd0);
    chk("s6 rst MMReadAddress", 32'(MMReadAddress), 32'd0);
    repeat (70) @(negedge Clock1);
    chk("s6 no StepDone", 32'(done_cnt), 32'(exp_done));

    // Step 7: clean step after reset
    base = wr_n;
    send_sym(BM2);
    wait_done(lat);
    exp_done++; exp_bsel = ~exp_bsel;
    chk("s7 latency", 32'(lat), 32'd66);
    check_step("s7", base, BM2, 1'b0);
    chk("s7 MMBlockSelect", 32'(MMBlockSelect), 32'(exp_bsel));

    // Step 8: Active low for 5 cycles at cnt=20
    base = wr_n;
    send_sym(BM3);
    repeat (20) @(negedge Clock1);
    chk("s8 cnt20 MMReadAddress", 32'(MMReadAddress), 32'd10);
    chk("s8 cnt20 MMWriteAddress", 32'(MMWriteAddress), 32'd41);
    Active = 1'b0;
    repeat (5) @(negedge Clock1);
    ew = '0;
    for (int i = 0; i < 4; i++) begin
      e = ref_state(164 + i, BM3, 1'b0);
      ew[i*8 +: 8] = e[7:0];
    end
    chk("s8 frozen MMReadAddress", 32'(MMReadAddress), 32'd10);
    chk("s8 frozen MMWriteAddress", 32'(MMWriteAddress), 32'd41);
    chk("s8 frozen MMMetric", MMMetric, ew);
    Active = 1'b1;
    wait_done(lat);
    exp_done++; exp_bsel = ~exp_bsel;
    chk("s8 latency", 32'(lat), 32'd71);
    check_step("s8", base, BM3, 1'b0);
    chk("s8 done count", 32'(done_cnt), 32'(exp_done));
    chk("s8 MMBlockSelect", 32'(MMBlockSelect), 32'(exp_bsel));

    chk("SurvValid tracks MMWriteEnable", 32'(sv_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
